aes_round_ctrl: RTL and testbench
=================================

Name: aes_round_ctrl

Overview:
Sequences the AES-128 encryption datapath (sub-bytes, shift-rows, mix-columns, add-round-key) over all rounds for one 128-bit block.
- Drives one step enable at a time, waits for that step's finished handshake, then loads the step result into the shared state register.
- Tracks the round number for the key schedule.
- Sits between the top-level block interface and the per-step datapath units.

Parameters:
NUM_ROUNDS, 10, number of full cipher rounds (round 0 is the initial add-round-key only)
ROUND_W, 4, width of round counter; must satisfy 2**ROUND_W > NUM_ROUNDS
TIMEOUT_CYC, 255, max cycles to wait for a step's finished before flagging error

Ports:
clk  in  1  system clock, rising edge
n_rst  in  1  asynchronous active-low reset
start  in  1  begin encryption of block presented on datapath input; sampled only in IDLE
abort  in  1  synchronous abort; returns to IDLE next cycle from any state
step_finished  in  1  finished flag from the step currently enabled (muxed upstream by step_sel)
in_load  out  1  one-cycle pulse: load plaintext into state register
step_en  out  1  enable for the currently selected step unit
step_sel  out  2  0=SUB, 1=SHIFT, 2=MIX, 3=ARK; selects step unit and state-register input mux
state_load  out  1  one-cycle pulse: capture selected step output into state register
round_num  out  ROUND_W  current round, 0..NUM_ROUNDS; feeds key schedule
busy  out  1  high from the cycle after start is accepted until done/error/abort
done  out  1  one-cycle pulse: ciphertext valid in state register
error  out  1  level; step timeout occurred; held until next accepted start or abort

Behaviour:
- Reset (n_rst=0, async): state=IDLE, round_num=0, timer=0. All outputs 0.
- States: IDLE, ARK0, SUB, SHIFT, MIX, ARK, DONE, ERR.
- IDLE: on start=1, pulse in_load the same cycle (combinational from start & IDLE); next state ARK0; round_num<=0.
- Step states ARK0/SUB/SHIFT/MIX/ARK:
  - step_en=1; step_sel per state (ARK0 uses 3).
  - When step_finished=1: state_load=1 that cycle (combinational) and advance.
  - Otherwise hold state, with step_en still asserted.
- Transitions:
  - ARK0->SUB with round_num<=1
  - SUB->SHIFT
  - SHIFT->MIX if round_num<NUM_ROUNDS; SHIFT->ARK if round_num==NUM_ROUNDS (final round skips MIX)
  - MIX->ARK
  - ARK->SUB with round_num++ if round_num<NUM_ROUNDS; ARK->DONE if round_num==NUM_ROUNDS
- DONE: done=1 for exactly one cycle, busy=0; next IDLE. round_num holds NUM_ROUNDS until the next start.
- Step timer:
  - Cleared on every step-state entry; increments each cycle in a step state while step_finished=0.
  - On reaching TIMEOUT_CYC with step_finished still 0: go to ERR.
  - If step_finished=1 in the same cycle the timer reaches TIMEOUT_CYC, finished wins.
- ERR: error=1, busy=0, no enables. Stays until start=1, which is accepted as in IDLE (clears error, pulses in_load, goes to ARK0) or abort=1 (goes to IDLE, clears error).
- abort:
  - Overrides everything except reset; next state IDLE, round_num<=0, error<=0.
  - state_load/in_load are suppressed in the cycle abort=1.
- start while busy: ignored. start and abort together: abort wins.
- Step counts: with step_finished tied 1, total step cycles = 1 + 4*(NUM_ROUNDS-1) + 3 = 40 for default.
- Outputs other than in_load and state_load are decoded from registered state only.

Decomposition:
- Package aes_pkg holds:
  - state enum type
  - step_sel encoding constants (STEP_SUB, STEP_SHIFT, STEP_MIX, STEP_ARK)
  - AES128_ROUNDS=10
- One natural sub-module, aes_step_timer:
  - inputs: clear, count enable
  - parameter: TIMEOUT_CYC
  - output: expired

Test Plan:
- Nominal, step_finished=1 always: start at cycle 0 -> in_load pulse cycle 0; step_sel sequence 3,(0,1,2,3)x9,0,1,3 over cycles 1-40; 40 state_load pulses; done=1 at cycle 41 only; round_num=10 at done.
- Delayed finish: step_finished asserted 3 cycles after each step_en -> each step lasts 4 cycles, done at cycle 161, exactly 40 state_load pulses, no error.
- Timeout: TIMEOUT_CYC=8, withhold step_finished in MIX of round 2 -> ERR entered after 8 wait cycles; error=1, busy=0; subsequent start clears error and restarts at ARK0 with round_num=0.
- Abort mid-run: abort=1 during SHIFT of round 5 with step_finished=1 -> no state_load that cycle; next cycle IDLE, round_num=0, busy=0, no done.
- start ignored while busy: pulse start at cycle 10 of a nominal run -> no in_load, sequence and done at cycle 41 unchanged.
- Async reset mid-run: n_rst low in round 4 between clock edges -> all outputs 0 immediately; after release, block idles until start.

Source files
------------

// File: rtl/aes_pkg.sv
`default_nettype none
// ============================================================================
// aes_pkg : shared types and encodings for the AES-128 round controller
// Rev 1.0
// ============================================================================
package aes_pkg;

    localparam int AES128_ROUNDS = 10;

    localparam logic [1:0] STEP_SUB   = 2'd0;
    localparam logic [1:0] STEP_SHIFT = 2'd1;
    localparam logic [1:0] STEP_MIX   = 2'd2;
    localparam logic [1:0] STEP_ARK   = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ARK0  = 3'd1,
        ST_SUB   = 3'd2,
        ST_SHIFT = 3'd3,
        ST_MIX   = 3'd4,
        ST_ARK   = 3'd5,
        ST_DONE  = 3'd6,
        ST_ERR   = 3'd7
    } state_t;

    function automatic logic is_step_state(input state_t s);
        return (s == ST_ARK0) || (s == ST_SUB) || (s == ST_SHIFT) ||
               (s == ST_MIX)  || (s == ST_ARK);
    endfunction

endpackage
`default_nettype wire

// File: rtl/aes_step_timer.sv
`default_nettype none
// ============================================================================
// aes_step_timer : counts wait cycles of one datapath step, flags a timeout
// Rev 1.0
// ============================================================================
module aes_step_timer #(
    parameter int TIMEOUT_CYC = 255
) (
    input  logic clk,
    input  logic n_rst,
    input  logic i_clear,
    input  logic i_count_en,
    output logic o_expired
);

    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

    logic [CNT_W-1:0] r_count;

    // Expiry fires in the cycle the count would reach TIMEOUT_CYC
    assign o_expired = i_count_en && (r_count == CNT_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_count_en && !o_expired) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

endmodule
`default_nettype wire

// File: rtl/aes_round_ctrl.sv
`default_nettype none
// ============================================================================
// aes_round_ctrl : sequences SUB/SHIFT/MIX/ARK steps over all AES-128 rounds
// Rev 1.0
// ============================================================================
module aes_round_ctrl
    import aes_pkg::*;
#(
    parameter int NUM_ROUNDS  = AES128_ROUNDS,
    parameter int ROUND_W     = 4,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic               clk,
    input  logic               n_rst,
    input  logic               start,
    input  logic               abort,
    input  logic               step_finished,
    output logic               in_load,
    output logic               step_en,
    output logic [1:0]         step_sel,
    output logic               state_load,
    output logic [ROUND_W-1:0] round_num,
    output logic               busy,
    output logic               done,
    output logic               error
);

    state_t             r_state;
    state_t             w_next;
    logic [ROUND_W-1:0] r_round;
    logic               w_in_step;
    logic               w_more_rounds;
    logic               w_accept;
    logic               w_advance;
    logic               w_expired;
    logic               w_timer_clr;
    logic               w_timer_en;

    assign w_in_step     = is_step_state(r_state);
    assign w_more_rounds = (r_round < ROUND_W'(NUM_ROUNDS));
    assign w_accept      = start && !abort && ((r_state == ST_IDLE) || (r_state == ST_ERR));
    assign w_advance     = w_in_step && step_finished && !abort;

    // Any state change restarts the wait count for the step being entered
    assign w_timer_clr = (w_next != r_state);
    assign w_timer_en  = w_in_step && !step_finished;

    aes_step_timer #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_timer (
        .clk        (clk),
        .n_rst      (n_rst),
        .i_clear    (w_timer_clr),
        .i_count_en (w_timer_en),
        .o_expired  (w_expired)
    );

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        if (abort) begin
            w_next = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE, ST_ERR: if (start) w_next = ST_ARK0;
                ST_ARK0:  if (step_finished) w_next = ST_SUB;
                ST_SUB:   if (step_finished) w_next = ST_SHIFT;
                ST_SHIFT: if (step_finished) w_next = w_more_rounds ? ST_MIX : ST_ARK;
                ST_MIX:   if (step_finished) w_next = ST_ARK;
                ST_ARK:   if (step_finished) w_next = w_more_rounds ? ST_SUB : ST_DONE;
                ST_DONE:  w_next = ST_IDLE;
                default:  w_next = ST_IDLE;
            endcase
            if (w_in_step && !step_finished && w_expired) begin
                w_next = ST_ERR;
            end
        end
    end

    always_comb begin
        step_en    = 1'b0;
        step_sel   = STEP_SUB;
        busy       = 1'b0;
        done       = 1'b0;
        error      = 1'b0;
        in_load    = w_accept;
        state_load = w_advance;
        case (r_state)
            ST_ARK0:  begin step_en = 1'b1; busy = 1'b1; step_sel = STEP_ARK;   end
            ST_SUB:   begin step_en = 1'b1; busy = 1'b1; step_sel = STEP_SUB;   end
            ST_SHIFT: begin step_en = 1'b1; busy = 1'b1; step_sel = STEP_SHIFT; end
            ST_MIX:   begin step_en = 1'b1; busy = 1'b1; step_sel = STEP_MIX;   end
            ST_ARK:   begin step_en = 1'b1; busy = 1'b1; step_sel = STEP_ARK;   end
            ST_DONE:  done  = 1'b1;
            ST_ERR:   error = 1'b1;
            default:  ;
        endcase
    end

    // Round counter holds through DONE and ERR until the next start or abort
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_round <= '0;
        end else if (abort || w_accept) begin
            r_round <= '0;
        end else if (w_advance && (r_state == ST_ARK0)) begin
            r_round <= ROUND_W'(1);
        end else if (w_advance && (r_state == ST_ARK) && w_more_rounds) begin
            r_round <= r_round + ROUND_W'(1);
        end
    end

    assign round_num = r_round;

endmodule
`default_nettype wire

// File: tb/tb_aes_round_ctrl.sv
`default_nettype none
// ============================================================================
// tb_aes_round_ctrl : randomized + directed self-checking bench with step model
// Rev 1.0
// ============================================================================
module tb_aes_round_ctrl;

    localparam int NR = 10;
    localparam int RW = 4;
    localparam int TO = 8;

    typedef enum int {M_IDLE, M_RUN, M_DONE, M_ERR} mph_t;

    logic          clk = 1'b0;
    logic          n_rst = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic          step_finished = 1'b0;
    logic          in_load, step_en, state_load, busy, done, error;
    logic [1:0]    step_sel;
    logic [RW-1:0] round_num;

    int   n_checks = 0;
    int   n_fail   = 0;
    int   q_sel[$];
    int   q_rnd[$];
    mph_t m_ph = M_IDLE;
    int   m_idx = 0;
    int   m_wait = 0;
    int   m_round = 0;
    int   cyc = 0;
    int   n_loads = 0;
    int   n_dones = 0;
    int   done_cyc = -1;

    aes_round_ctrl #(
        .NUM_ROUNDS  (NR),
        .ROUND_W     (RW),
        .TIMEOUT_CYC (TO)
    ) dut (
        .clk           (clk),
        .n_rst         (n_rst),
        .start         (start),
        .abort         (abort),
        .step_finished (step_finished),
        .in_load       (in_load),
        .step_en       (step_en),
        .step_sel      (step_sel),
        .state_load    (state_load),
        .round_num     (round_num),
        .busy          (busy),
        .done          (done),
        .error         (error)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, act, exp);
        end
    endtask

    // Step list of one block: ARK0, then SUB/SHIFT/(MIX)/ARK per round
    function automatic void build_steps();
        q_sel.delete();
        q_rnd.delete();
        q_sel.push_back(3); q_rnd.push_back(0);
        for (int r = 1; r <= NR; r++) begin
            q_sel.push_back(0); q_rnd.push_back(r);
            q_sel.push_back(1); q_rnd.push_back(r);
            if (r < NR) begin
                q_sel.push_back(2); q_rnd.push_back(r);
            end
            q_sel.push_back(3); q_rnd.push_back(r);
        end
    endfunction

    function automatic logic [11:0] model_out(input bit st, input bit ab, input bit fn);
        logic          il  = 1'b0;
        logic          en  = 1'b0;
        logic          sl  = 1'b0;
        logic          bz  = 1'b0;
        logic          dn  = 1'b0;
        logic          er  = 1'b0;
        logic [1:0]    sel = 2'd0;
        logic [RW-1:0] rn  = RW'(m_round);
        case (m_ph)
            M_IDLE: il = st && !ab;
            M_ERR:  begin il = st && !ab; er = 1'b1; end
            M_RUN:  begin
                en  = 1'b1;
                bz  = 1'b1;
                sel = 2'(q_sel[m_idx]);
                rn  = RW'(q_rnd[m_idx]);
                sl  = fn && !ab;
            end
            M_DONE: dn = 1'b1;
            default: ;
        endcase
        return {il, en, sel, sl, rn, bz, dn, er};
    endfunction

    function automatic void model_step(input bit st, input bit ab, input bit fn);
        if (ab) begin
            m_ph    = M_IDLE;
            m_round = 0;
            return;
        end
        case (m_ph)
            M_IDLE, M_ERR: if (st) begin
                m_ph = M_RUN; m_idx = 0; m_wait = 0; m_round = 0;
            end
            M_RUN: begin
                if (fn) begin
                    m_idx++;
                    m_wait = 0;
                    if (m_idx == q_sel.size()) begin
                        m_ph    = M_DONE;
                        m_round = NR;
                    end
                end else begin
                    m_wait++;
                    if (m_wait == TO) begin
                        m_round = q_rnd[m_idx];
                        m_ph    = M_ERR;
                    end
                end
            end
            M_DONE: m_ph = M_IDLE;
            default: ;
        endcase
    endfunction

    task automatic cycle(input bit st, input bit ab, input bit fn);
        @(negedge clk);
        start         = st;
        abort         = ab;
        step_finished = fn;
        #1;
        chk("outs", {in_load, step_en, step_sel, state_load, round_num, busy, done, error},
            model_out(st, ab, fn));
        if (state_load) n_loads++;
        if (done) begin
            n_dones++;
            done_cyc = cyc;
        end
        model_step(st, ab, fn);
        cyc++;
    endtask

    function automatic bit at_step(input int sel, input int rnd);
        return (m_ph == M_RUN) && (q_sel[m_idx] == sel) && (q_rnd[m_idx] == rnd);
    endfunction

    task automatic clr_stats();
        cyc = 0; n_loads = 0; n_dones = 0; done_cyc = -1;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int w;
        int p;
        build_steps();

        repeat (2) @(negedge clk);
        #1;
        chk("rst_outs", {in_load, step_en, step_sel, state_load, round_num, busy, done, error}, 0);
        n_rst = 1'b1;
        repeat (3) cycle(0, 0, 0);

        // Nominal run with a stray start at cycle 10
        clr_stats();
        cycle(1, 0, 1);
        for (int i = 0; i < 45; i++) cycle(cyc == 10, 0, 1);
        chk("nom_loads", n_loads, 40);
        chk("nom_done_cyc", done_cyc, 41);
        chk("nom_dones", n_dones, 1);

        // Each step finishes 3 cycles after its enable
        clr_stats();
        cycle(1, 0, 0);
        for (int i = 0; i < 170; i++) cycle(0, 0, (m_ph == M_RUN) && (m_wait == 3));
        chk("dly_loads", n_loads, 40);
        chk("dly_done_cyc", done_cyc, 161);

        // Timeout in MIX of round 2, then restart
        cycle(1, 0, 1);
        for (int i = 0; i < 20 && !at_step(2, 2); i++) cycle(0, 0, 1);
        w = 0;
        for (int i = 0; i < 20; i++) begin
            cycle(0, 0, 0);
            if (error) break;
            w++;
        end
        chk("to_wait", w, TO);
        chk("to_error", error, 1);
        chk("to_busy", busy, 0);
        cycle(0, 0, 0);
        cycle(1, 0, 0);
        cycle(0, 0, 1);
        chk("restart_round", round_num, 0);
        chk("restart_sel", step_sel, 3);
        chk("restart_err", error, 0);

        // Abort during SHIFT of round 5
        clr_stats();
        for (int i = 0; i < 60 && !at_step(1, 5); i++) cycle(0, 0, 1);
        cycle(0, 1, 1);
        chk("abort_load", state_load, 0);
        cycle(0, 0, 1);
        chk("abort_round", round_num, 0);
        chk("abort_busy", busy, 0);
        repeat (50) cycle(0, 0, 1);
        chk("abort_nodone", n_dones, 0);

        // Asynchronous reset in round 4
        cycle(1, 0, 1);
        for (int i = 0; i < 30 && !at_step(0, 4); i++) cycle(0, 0, 1);
        @(negedge clk);
        start = 1'b0; abort = 1'b0; step_finished = 1'b1;
        #2 n_rst = 1'b0;
        #1;
        chk("arst_outs", {in_load, step_en, step_sel, state_load, round_num, busy, done, error}, 0);
        m_ph = M_IDLE; m_round = 0;
        #1 n_rst = 1'b1;
        clr_stats();
        repeat (10) cycle(0, 0, 1);
        chk("arst_idle", n_loads, 0);

        // Randomized traffic, including timeouts, aborts and stray starts
        for (int blk = 0; blk < 15; blk++) begin
            p = $urandom_range(30, 100);
            for (int i = 0; i < 200; i++) begin
                cycle($urandom_range(0, 19) == 0, $urandom_range(0, 199) == 0,
                      $urandom_range(0, 99) < p);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
